regfile_read_sched: RTL and testbench
=====================================

# regfile_read_sched

Round-robin scheduler sharing the register file's single 32-to-1 read multiplexer among NUM_REQ requesters in the multicycle processor. Default requesters: 0 = rs1 fetch, 1 = rs2 fetch, 2 = debug/trace port. It accepts one read per cycle, drives the mux select from a register, and captures the mux output. It returns a tagged response two cycles after acceptance. Same-cycle register-file writes are forwarded, and register 0 reads as zero.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- ZERO_REG, 1, when 1 a read of index 0 returns 0
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  NUM_REQ  per-requester read request
- req_addr  input  NUM_REQ*ADDR_W  packed indices; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  output  NUM_REQ  one-hot grant; a read is accepted when req_valid[i] && req_ready[i]
- mux_select  output  ADDR_W  select to the register-file read mux, registered
- mux_out  input  DATA_W  combinational data returned by the read mux
- wr_en  input  1  register-file write this cycle
- wr_addr  input  ADDR_W  write index
- wr_data  input  DATA_W  write data
- rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle wide
- rsp_data  output  DATA_W  read data, valid while any rsp_valid bit is high

## Operation
- Arbitration is combinational from req_valid and the priority pointer ptr, which is in 0..NUM_REQ-1.
- The arbiter grants the first valid requester found searching ptr, ptr+1, … modulo NUM_REQ.
- req_ready has at most one bit set. It is all-zero when no request is valid or while rst_n is low.
- On acceptance of requester g:
  - ptr <= (g+1) mod NUM_REQ.
  - mux_select <= req_addr[g].
  - Stage-1 tag s1_id <= g; s1_v <= 1.
- With no acceptance, ptr holds, mux_select holds its last value, and s1_v <= 0.
- Stage 2 samples data only when s1_v=1:
  - If ZERO_REG && mux_select==0: data = 0.
  - Else if wr_en && wr_addr==mux_select: data = wr_data (forward; takes priority over mux_out).
  - Else: data = mux_out.
  - rsp_data <= data; rsp_valid <= one-hot(s1_id).
- With s1_v=0, rsp_valid <= 0 and rsp_data holds.
- Requesters have no back-pressure on responses. A requester must consume rsp_data in the cycle its rsp_valid bit is high.
- A requester may drop req_valid or change req_addr before it is granted. Nothing is latched until the accept edge.
- Forwarding uses the register index only. If ZERO_REG=1, a write to index 0 is never forwarded.

## Timing
- Cycle N: accept at the rising edge ending cycle N.
- Cycle N+1: mux_select shows the accepted index; mux_out is sampled at the edge ending N+1.
- Cycle N+2: rsp_valid and rsp_data are visible.
- Latency is 2 cycles from accept to response. Throughput is one read per cycle across all requesters, fully pipelined.
- Back-to-back accepts produce back-to-back responses in grant order.
- Reset values: ptr=0, mux_select=0, s1_v=0, s1_id=0, rsp_valid=0, rsp_data=0, req_ready=0.
- Reset asserted mid-operation clears the in-flight stage-1 and stage-2 entries immediately. Those reads produce no response, and requesters must reissue them.
- The first cycle after rst_n deasserts may grant.
- Forward path: wr_en, wr_addr and wr_data are sampled in the same cycle as mux_out (N+1). A write in cycle N is not forwarded; it must already be visible on mux_out in N+1.

## Test plan
- Single read, no contention:
  - Stimulus: reg5 holds 0xDEAD_BEEF; req_valid=3'b001 with addr 5 for one cycle.
  - Required: req_ready=3'b001 in that cycle; mux_select=5 next cycle; rsp_valid=3'b001 with rsp_data=0xDEAD_BEEF two cycles after accept.
- Round-robin under full load:
  - Stimulus: all three requesters valid continuously, addrs 1/2/3.
  - Required: grants 0,1,2,0,1,2 on consecutive cycles; responses in the same order, one per cycle, with the matching register values.
- Pointer skip:
  - Stimulus: after a grant to requester 0, only requester 2 is valid.
  - Required: requester 2 granted; ptr becomes 0. Next, requesters 0 and 1 both valid: requester 0 granted first.
- Zero register and forwarding:
  - Stimulus: read addr 0 while reg0 backing holds 0x1234. Then read addr 7 with wr_en=1, wr_addr=7, wr_data=0xCAFE_F00D in cycle N+1.
  - Required: rsp_data=0 for the first read; rsp_data=0xCAFE_F00D for the second.
- Reset mid-pipeline:
  - Stimulus: accept reads on two consecutive cycles, then pull rst_n low for one cycle before either response.
  - Required: no rsp_valid pulses; all outputs at reset values. First grant after release goes to requester 0 when all are valid.

Source files
------------

// File: rtl/regfile_read_sched_if.sv
// Register-file read scheduler bus.
// Groups the request/grant handshake, the read-mux select/data pair, the
// write-forward port and the tagged response into one bundle.
//   slave  : the scheduler (takes requests, drives grants/select/response)
//   master : requesters plus the register file (drive requests, mux data, writes)
interface regfile_read_sched_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         mux_select;
  logic [DATA_W-1:0]         mux_out;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_addr, mux_out, wr_en, wr_addr, wr_data,
    output req_ready, mux_select, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, mux_out, wr_en, wr_addr, wr_data,
    input  req_ready, mux_select, rsp_valid, rsp_data
  );
endinterface

// File: rtl/regfile_read_sched.sv
// Round-robin scheduler for the register file's single read mux.
// One read is accepted per cycle; the accepted index is registered onto
// mux_select, the mux output (or a same-cycle write, or zero for r0) is
// captured one cycle later, and a one-hot tagged response appears two
// cycles after acceptance.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : regfile_read_sched_if.slave (requests, grants, mux select/data,
//           write-forward port, tagged response)
module regfile_read_sched #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_read_sched_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  mux_select_q, mux_select_d;
  logic               s1_v_q, s1_v_d;
  logic [PTR_W-1:0]   s1_id_q, s1_id_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic               found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  s2_data;

  // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid requester.
  // Grants are forced off while reset is asserted.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!rst_n) found = 1'b0;
  end

  assign grant         = found ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.req_ready = grant;

  // Zero register wins over forwarding, so a write to r0 is never forwarded.
  always_comb begin
    if (ZERO_REG && (mux_select_q == '0))
      s2_data = '0;
    else if (bus.wr_en && (bus.wr_addr == mux_select_q))
      s2_data = bus.wr_data;
    else
      s2_data = bus.mux_out;
  end

  always_comb begin
    ptr_d        = ptr_q;
    mux_select_d = mux_select_q;
    s1_v_d       = 1'b0;
    s1_id_d      = s1_id_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    if (found) begin
      ptr_d        = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      mux_select_d = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
      s1_v_d       = 1'b1;
      s1_id_d      = gnt_idx;
    end
    if (s1_v_q) begin
      rsp_valid_d = NUM_REQ'(1) << s1_id_q;
      rsp_data_d  = s2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      mux_select_q <= '0;
      s1_v_q       <= 1'b0;
      s1_id_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mux_select_q <= mux_select_d;
      s1_v_q       <= s1_v_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.mux_select = mux_select_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_regfile_read_sched.sv
// Directed bench for regfile_read_sched with a response scoreboard.
module tb_regfile_read_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_read_sched_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_read_sched #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] rf [32];
  assign bus.mux_out = rf[bus.mux_select];

  typedef struct {
    logic [2:0]  vld;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [2:0] eg, input logic [31:0] ed,
                       input bit push, input string nm);
    exp_t x;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    #1;
    chk(nm, 32'(bus.req_ready), 32'(eg));
    if (push && eg != 3'b000) begin
      x.vld  = eg;
      x.data = ed;
      x.due  = cyc + 2;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 3'b000, 32'h0, 1'b0, "idle_gnt");
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (|bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)",
                   bus.rsp_valid, cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_missing: got no response expected %b/%h by cycle %0d",
                 q[0].vld, q[0].data, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
    rf[0]  = 32'h0000_1234;
    rf[1]  = 32'h1111_1111;
    rf[2]  = 32'h2222_2222;
    rf[3]  = 32'h3333_3333;
    rf[5]  = 32'hDEAD_BEEF;
    rf[7]  = 32'h7777_7777;
    rf[8]  = 32'h8888_8888;
    rf[9]  = 32'h9999_0000;
    rf[10] = 32'h1010_1010;
    rf[11] = 32'h1111_0B0B;

    rst_n         = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mux_select", 32'(bus.mux_select), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    @(negedge clk);
    bus.req_valid = 3'b000;
    rst_n = 1'b1;

    // Round-robin under full load from ptr=0.
    for (int r = 0; r < 2; r++) begin
      drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b001, rf[1], 1'b1, "rr_gnt0");
      drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b010, rf[2], 1'b1, "rr_gnt1");
      drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b100, rf[3], 1'b1, "rr_gnt2");
    end

    // Single read, no contention (ptr=0 -> 1).
    drive(3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 3'b001, 32'hDEAD_BEEF, 1'b1, "single_gnt");
    idle(1);
    chk("single_mux_select", 32'(bus.mux_select), 32'd5);

    // Pointer skip: ptr=1, only req2 valid -> ptr wraps to 0.
    drive(3'b100, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 3'b100, rf[9], 1'b1, "skip_gnt2");
    drive(3'b011, 5'd10, 5'd11, 5'd0, 1'b0, 5'd0, 32'h0, 3'b001, rf[10], 1'b1, "skip_gnt0");
    drive(3'b011, 5'd10, 5'd11, 5'd0, 1'b0, 5'd0, 32'h0, 3'b010, rf[11], 1'b1, "skip_gnt1");

    // Zero register (with a write to r0 that must not forward), then forward to r7.
    drive(3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 3'b001, 32'h0, 1'b1, "zero_gnt");
    drive(3'b001, 5'd7, 5'd0, 5'd0, 1'b1, 5'd0, 32'h5555_5555, 3'b001, 32'hCAFE_F00D, 1'b1, "fwd_gnt");
    drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hCAFE_F00D, 3'b000, 32'h0, 1'b0, "fwd_idle");
    // Write in the accept cycle itself is not forwarded.
    drive(3'b001, 5'd8, 5'd0, 5'd0, 1'b1, 5'd8, 32'hBAD0_0008, 3'b001, rf[8], 1'b1, "nofwd_gnt");
    idle(3);

    // Reset mid-pipeline: ptr=1, two accepts then reset before any response is sampled.
    drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b010, 32'h0, 1'b0, "pre_rst_gnt1");
    drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b100, 32'h0, 1'b0, "pre_rst_gnt2");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_rst_mux_select", 32'(bus.mux_select), 32'h0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_rsp_data", bus.rsp_data, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 3'b001, rf[1], 1'b1, "post_rst_gnt0");
    idle(4);

    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
